// File: rtl/icache_refill_controller_pkg.sv
// Shared refill types: FSM states, line geometry constants and beat index type.
package ICacheRefillTypes;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      FILL = 2'd2,
      TAG  = 2'd3
   } RefillState;

   localparam int ICACHE_LINE_WORDS            = 8;
   localparam int ICACHE_WORD_BYTES            = 4;
   localparam int ICACHE_LINE_OFFSET_BIT_WIDTH = $clog2(ICACHE_LINE_WORDS * ICACHE_WORD_BYTES);

   typedef logic [$clog2(ICACHE_LINE_WORDS)-1:0] RefillBeatIndexPath;

endpackage

// File: rtl/icache_refill_controller_if.sv
// Memory-side port of the refill controller: one line request, then in-order beats
// that the controller must always accept (no response backpressure).
interface icache_refill_controller_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  memReqValid;
   logic                  memReqReady;
   logic [ADDR_WIDTH-1:0] memReqAddr;
   logic                  memRspValid;
   logic [DATA_WIDTH-1:0] memRspData;

   modport master (
      output memReqValid,
      output memReqAddr,
      input  memReqReady,
      input  memRspValid,
      input  memRspData
   );

   modport slave (
      input  memReqValid,
      input  memReqAddr,
      output memReqReady,
      output memRspValid,
      output memRspData
   );
endinterface

// File: rtl/icache_refill_controller.sv
// I-cache line refill sequencer: miss -> request -> LINE_WORDS beats -> tag write + done pulse.
// Miss to done is LINE_WORDS+2 cycles with no stalls; request waits on memReqReady, beats are never backpressured.
module icache_refill_controller
   import ICacheRefillTypes::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    icMiss,
   input  logic [ADDR_WIDTH-1:0]   icMissAddr,
   input  logic                    flush,
   output logic                    icStall,
   output logic                    refillDone,
   icache_refill_controller_if.master mem,
   output logic                    fillWE,
   output logic [ADDR_WIDTH-1:0]   fillAddr,
   output logic [DATA_WIDTH-1:0]   fillData,
   output logic                    tagWE,
   output logic [ADDR_WIDTH-1:0]   tagAddr
);

   localparam int WORD_BYTES = DATA_WIDTH / 8;
   localparam int WORD_SHIFT = $clog2(WORD_BYTES);
   localparam int BEAT_W     = $clog2(LINE_WORDS);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_WORDS * WORD_BYTES - 1);

   RefillState            state;
   RefillState            state_next;
   logic [BEAT_W-1:0]     beat_cnt;
   logic [ADDR_WIDTH-1:0] line_addr;
   logic                  dropped;
   logic                  last_beat;
   logic                  accept_miss;

   assign last_beat   = (beat_cnt == BEAT_W'(LINE_WORDS - 1));
   assign accept_miss = icMiss && !flush;

   // State register plus the per-refill bookkeeping that rides along with it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         beat_cnt  <= '0;
         dropped   <= 1'b0;
         line_addr <= '0;
         icStall   <= 1'b0;
      end else begin
         state   <= state_next;
         icStall <= (state_next != IDLE);
         case (state)
            IDLE: begin
               if (accept_miss) begin
                  line_addr <= icMissAddr & LINE_MASK;
                  dropped   <= 1'b0;
               end
            end
            REQ: begin
               if (mem.memReqReady) begin
                  beat_cnt <= '0;
                  dropped  <= flush;
               end
            end
            FILL: begin
               if (mem.memRspValid) begin
                  beat_cnt <= beat_cnt + BEAT_W'(1);
               end
               if (flush) begin
                  dropped <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // A flush in REQ only withdraws the request if memory has not taken it yet;
   // once accepted, the line is drained and installed but not replayed.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept_miss) state_next = REQ;
         REQ: begin
            if (mem.memReqReady) begin
               state_next = FILL;
            end else if (flush) begin
               state_next = IDLE;
            end
         end
         FILL: if (mem.memRspValid && last_beat) state_next = TAG;
         TAG:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mem.memReqValid = 1'b0;
      mem.memReqAddr  = '0;
      fillWE          = 1'b0;
      fillAddr        = '0;
      fillData        = '0;
      tagWE           = 1'b0;
      tagAddr         = '0;
      refillDone      = 1'b0;
      case (state)
         REQ: begin
            mem.memReqValid = 1'b1;
            mem.memReqAddr  = line_addr;
         end
         FILL: begin
            fillWE   = mem.memRspValid;
            fillAddr = line_addr + (ADDR_WIDTH'(beat_cnt) << WORD_SHIFT);
            fillData = mem.memRspData;
         end
         TAG: begin
            tagWE      = 1'b1;
            tagAddr    = line_addr;
            refillDone = !dropped && !flush;
         end
         default: begin
         end
      endcase
   end

   stray_rsp_beat: assert property (@(posedge clk) disable iff (!rst)
                                    !(mem.memRspValid && state != FILL))
      else $warning("memRspValid outside FILL ignored (protocol violation)");

endmodule

// File: tb/tb_icache_refill_controller.sv
// Directed bench for the refill controller with cycle-exact hand-computed expectations.
module tb_icache_refill_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        icMiss;
   logic [31:0] icMissAddr;
   logic        flush;
   logic        icStall;
   logic        refillDone;
   logic        fillWE;
   logic [31:0] fillAddr;
   logic [31:0] fillData;
   logic        tagWE;
   logic [31:0] tagAddr;

   int n_checks = 0;
   int n_pass   = 0;

   icache_refill_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mif ();

   icache_refill_controller #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .LINE_WORDS(8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .icMiss    (icMiss),
      .icMissAddr(icMissAddr),
      .flush     (flush),
      .icStall   (icStall),
      .refillDone(refillDone),
      .mem       (mif),
      .fillWE    (fillWE),
      .fillAddr  (fillAddr),
      .fillData  (fillData),
      .tagWE     (tagWE),
      .tagAddr   (tagAddr)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance to just after the next rising edge, where new inputs are applied.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Full unstalled refill: miss at cycle 0, ready at 1, beats 2..9, TAG at 10, IDLE at 11.
   task automatic refill(input logic [31:0] miss_addr, input logic [31:0] line,
                         input logic [31:0] dbase, input logic busy_miss);
      icMiss = 1'b1;
      icMissAddr = miss_addr;
      @(negedge clk);
      chk("miss_cycle_stall", icStall, 1'b0);
      cyc();
      icMiss = busy_miss;
      icMissAddr = 32'h0000_9000;
      mif.memReqReady = 1'b1;
      @(negedge clk);
      chk("req_valid", mif.memReqValid, 1'b1);
      chk("req_addr", mif.memReqAddr, line);
      chk("req_stall", icStall, 1'b1);
      cyc();
      mif.memReqReady = 1'b0;
      for (int b = 0; b < 8; b++) begin
         mif.memRspValid = 1'b1;
         mif.memRspData = dbase + 32'(b);
         @(negedge clk);
         chk("fill_we", fillWE, 1'b1);
         chk("fill_addr", fillAddr, line + 32'(4 * b));
         chk("fill_data", fillData, dbase + 32'(b));
         chk("fill_no_done", refillDone, 1'b0);
         cyc();
      end
      mif.memRspValid = 1'b0;
      mif.memRspData = '0;
      @(negedge clk);
      chk("tag_we", tagWE, 1'b1);
      chk("tag_addr", tagAddr, line);
      chk("tag_done", refillDone, 1'b1);
      chk("tag_no_fill", fillWE, 1'b0);
      cyc();
      icMiss = 1'b0;
      @(negedge clk);
      chk("idle_stall", icStall, 1'b0);
      chk("idle_done", refillDone, 1'b0);
      chk("idle_tag_we", tagWE, 1'b0);
      cyc();
      @(negedge clk);
      chk("idle_hold", icStall, 1'b0);
      chk("idle_no_req", mif.memReqValid, 1'b0);
      cyc();
   endtask

   initial begin
      int n_we;
      int n_done;
      int n_tag;
      logic [9:0] beat_pat;
      rst = 1'b0;
      icMiss = 1'b0;
      icMissAddr = '0;
      flush = 1'b0;
      mif.memReqReady = 1'b0;
      mif.memRspValid = 1'b0;
      mif.memRspData = '0;
      cyc();
      cyc();
      @(negedge clk);
      chk("rst_stall", icStall, 1'b0);
      chk("rst_req", mif.memReqValid, 1'b0);
      chk("rst_req_addr", mif.memReqAddr, 32'h0);
      chk("rst_fill_we", fillWE, 1'b0);
      chk("rst_tag_we", tagWE, 1'b0);
      chk("rst_done", refillDone, 1'b0);
      cyc();
      rst = 1'b1;
      cyc();

      // Basic refill.
      refill(32'h0000_1234, 32'h0000_1220, 32'hD000_0000, 1'b0);

      // Request backpressure for 3 cycles, then a 2-cycle gap after beat 3.
      icMiss = 1'b1;
      icMissAddr = 32'h0000_ABCD;
      cyc();
      icMiss = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mif.memReqReady = (i == 3);
         @(negedge clk);
         chk("bp_req_valid", mif.memReqValid, 1'b1);
         chk("bp_req_addr", mif.memReqAddr, 32'h0000_ABC0);
         cyc();
      end
      mif.memReqReady = 1'b0;
      beat_pat = 10'b11_1100_1111;
      n_we = 0;
      n_done = 0;
      for (int i = 0; i < 12; i++) begin
         mif.memRspValid = (i < 10) ? beat_pat[i] : 1'b0;
         mif.memRspData = 32'hA500_0000 + 32'(i);
         @(negedge clk);
         if (fillWE) n_we++;
         if (refillDone) n_done++;
         if (i == 6) chk("gap_fill_addr", fillAddr, 32'h0000_ABD0);
         if (i == 4) chk("gap_no_we", fillWE, 1'b0);
         if (i == 10) chk("gap_done", refillDone, 1'b1);
         if (i == 11) chk("gap_idle", icStall, 1'b0);
         cyc();
      end
      mif.memRspValid = 1'b0;
      chk("gap_we_count", n_we, 8);
      chk("gap_done_count", n_done, 1);

      // Flush in REQ before ready: request withdrawn.
      icMiss = 1'b1;
      icMissAddr = 32'h0000_2000;
      cyc();
      icMiss = 1'b0;
      @(negedge clk);
      chk("fr_req_valid", mif.memReqValid, 1'b1);
      cyc();
      flush = 1'b1;
      @(negedge clk);
      chk("fr_req_held", mif.memReqValid, 1'b1);
      cyc();
      flush = 1'b0;
      n_we = 0;
      n_tag = 0;
      n_done = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) chk("fr_idle_stall", icStall, 1'b0);
         if (i == 0) chk("fr_req_dropped", mif.memReqValid, 1'b0);
         if (fillWE) n_we++;
         if (tagWE) n_tag++;
         if (refillDone) n_done++;
         cyc();
      end
      chk("fr_fill_count", n_we, 0);
      chk("fr_tag_count", n_tag, 0);
      chk("fr_done_count", n_done, 0);

      // Flush during FILL at beat 4: line installed, no replay.
      icMiss = 1'b1;
      icMissAddr = 32'h0000_3008;
      cyc();
      icMiss = 1'b0;
      mif.memReqReady = 1'b1;
      cyc();
      mif.memReqReady = 1'b0;
      n_we = 0;
      for (int b = 0; b < 8; b++) begin
         mif.memRspValid = 1'b1;
         mif.memRspData = 32'hF000_0000 + 32'(b);
         flush = (b == 4);
         @(negedge clk);
         if (fillWE) n_we++;
         cyc();
      end
      mif.memRspValid = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      chk("ff_fill_count", n_we, 8);
      chk("ff_tag_we", tagWE, 1'b1);
      chk("ff_tag_addr", tagAddr, 32'h0000_3000);
      chk("ff_no_done", refillDone, 1'b0);
      cyc();
      icMiss = 1'b1;
      icMissAddr = 32'h0000_4000;
      @(negedge clk);
      chk("ff_idle_stall", icStall, 1'b0);
      cyc();
      icMiss = 1'b0;
      @(negedge clk);
      chk("ff_new_req", mif.memReqValid, 1'b1);
      chk("ff_new_addr", mif.memReqAddr, 32'h0000_4000);
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      cyc();

      // Stray beat in IDLE, then a refill with icMiss held during FILL.
      mif.memRspValid = 1'b1;
      mif.memRspData = 32'hBAD0_BAD0;
      @(negedge clk);
      chk("stray_no_we", fillWE, 1'b0);
      cyc();
      mif.memRspValid = 1'b0;
      @(negedge clk);
      chk("stray_idle", icStall, 1'b0);
      cyc();
      refill(32'h0000_5010, 32'h0000_5000, 32'h5500_0000, 1'b1);

      // Reset mid-FILL after 3 beats.
      icMiss = 1'b1;
      icMissAddr = 32'h0000_6000;
      cyc();
      icMiss = 1'b0;
      mif.memReqReady = 1'b1;
      cyc();
      mif.memReqReady = 1'b0;
      for (int b = 0; b < 3; b++) begin
         mif.memRspValid = 1'b1;
         mif.memRspData = 32'h6600_0000 + 32'(b);
         cyc();
      end
      mif.memRspValid = 1'b0;
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      @(negedge clk);
      chk("mr_stall", icStall, 1'b0);
      chk("mr_req", mif.memReqValid, 1'b0);
      chk("mr_fill_we", fillWE, 1'b0);
      chk("mr_fill_addr", fillAddr, 32'h0);
      chk("mr_tag_we", tagWE, 1'b0);
      chk("mr_done", refillDone, 1'b0);
      cyc();
      refill(32'h0000_7004, 32'h0000_7000, 32'h7700_0000, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/icache_refill_controller.md
Name: icache_refill_controller

Overview:
Sequences I-cache line refills for the fetch stage. It accepts a miss from fetch, issues one line-aligned request to the memory port, and streams the returning beats into the I-cache data array. It then writes the tag/valid entry and pulses a done signal so fetch can replay. It sits between the fetch-stage I-cache read path and the memory-side port. It owns stall generation during refills and handles pipeline flush while a refill is in flight.

Parameters:
ADDR_WIDTH, 32, byte-address width (matches PhyAddrPath).
DATA_WIDTH, 32, bits per memory beat and per array word write.
LINE_WORDS, 8, beats per cache line; power of two, at least 2.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-low.
icMiss  in  1  fetch saw icRE with no hit this cycle.
icMissAddr  in  ADDR_WIDTH  fetch head address of the miss.
flush  in  1  pipeline redirect; the current refill must not trigger a replay.
icStall  out  1  refill in progress; fetch holds.
refillDone  out  1  one-cycle pulse; line installed, fetch may replay.
memReqValid  out  1  line request valid.
memReqReady  in  1  memory accepts the request.
memReqAddr  out  ADDR_WIDTH  line-aligned request address.
memRspValid  in  1  response beat valid; beats arrive in order, no backpressure.
memRspData  in  DATA_WIDTH  response beat data.
fillWE  out  1  data-array word write enable.
fillAddr  out  ADDR_WIDTH  byte address of the word written.
fillData  out  DATA_WIDTH  word data.
tagWE  out  1  tag/valid write enable.
tagAddr  out  ADDR_WIDTH  line address for the tag write.

Behaviour:
- Constants: OFFSET = log2(LINE_WORDS*DATA_WIDTH/8). lineAddr = icMissAddr with the low OFFSET bits cleared. beatCnt is log2(LINE_WORDS) bits wide.
- States: IDLE, REQ, FILL, TAG.
- Reset (rst=0 at a clock edge):
  - State goes to IDLE; beatCnt=0; dropped=0; lineAddr=0.
  - All outputs are 0 from the following cycle.
  - Reset mid-refill abandons the refill. The memory side is reset in the same cycle.
- IDLE:
  - icMiss=1 and flush=0: latch lineAddr, clear dropped, go to REQ.
  - icMiss with flush=1 in the same cycle: ignored, stay in IDLE.
- REQ:
  - memReqValid=1; memReqAddr=lineAddr, held stable until accepted.
  - memReqReady=1: go to FILL with beatCnt=0; dropped = flush.
  - flush=1 and memReqReady=0: withdraw the request and go to IDLE. No memory traffic is outstanding.
- FILL:
  - Combinational pass-through: fillWE = memRspValid; fillAddr = lineAddr + beatCnt*(DATA_WIDTH/8); fillData = memRspData.
  - Each valid beat increments beatCnt.
  - A valid beat with beatCnt = LINE_WORDS-1: go to TAG; beatCnt wraps to 0.
  - flush in FILL sets dropped. The FSM still drains every beat and writes the line, because the data is correct.
- TAG:
  - One cycle: tagWE=1, tagAddr=lineAddr, refillDone = !dropped && !flush. Then go to IDLE.
- icStall = (state != IDLE), registered.
  - The fetch stage stalls itself in the miss cycle from its own miss detection.
- icMiss while not in IDLE is ignored. Fetch re-presents the miss after replay if it still misses.
- memRspValid outside FILL is ignored and flagged by a simulation assertion (protocol violation).
- Latency: miss at cycle 0 -> REQ at cycle 1. With ready at cycle 1 and back-to-back beats at cycles 2..9, TAG/refillDone is at cycle 10 and IDLE at cycle 11.
- A new miss is accepted no earlier than cycle 11.
- Gapped beats stretch FILL with no limit; there is no timeout.

Decomposition:
- Shared package ICacheRefillTypes holds:
  - the RefillState enum;
  - ICACHE_LINE_WORDS and ICACHE_LINE_OFFSET_BIT_WIDTH constants;
  - RefillBeatIndexPath typedef.
- No sub-module is needed. FSM and beat counter sit in one module, about 150 lines.

Test Plan:
- Basic refill: miss at 0x0000_1234, ready immediate, 8 back-to-back beats D0..D7 -> memReqAddr=0x0000_1220, fillAddr 0x1220..0x123C with D0..D7, tagWE and refillDone at cycle 10, icStall low at cycle 11.
- Request backpressure and gaps: memReqReady low for 3 cycles, and a 2-cycle gap after beat 3 -> memReqAddr stable throughout, exactly 8 fillWE pulses, refillDone once after the last beat.
- Flush in REQ before ready: flush at cycle 2, ready never given -> IDLE at cycle 3, no fillWE, no tagWE, no refillDone.
- Flush during FILL at beat 4 -> all 8 words written, tagWE=1, refillDone=0, new miss accepted after IDLE.
- Miss while busy and stray beat: icMiss=1 during FILL, and memRspValid=1 in IDLE -> miss ignored, stray beat produces no fillWE, assertion fires.
- Reset mid-FILL after 3 beats (rst=0 for one cycle) -> IDLE next cycle, all outputs 0, beatCnt=0; a fresh miss then completes normally.
